// File: rtl/block_max_exp_stream_if.sv
// Stream bundle for block_max_exp_stream: exponent beats in, one block max out.
// The master drives beats and accepts results; the slave is the max finder.
interface block_max_exp_stream_if #(
  parameter int EXP_WIDTH = 4,
  parameter int LANES     = 16,
  parameter int BEATS     = 4
);
  localparam int IDX_W = $clog2(LANES * BEATS);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*EXP_WIDTH-1:0] in_exp;
  logic                       out_valid;
  logic                       out_ready;
  logic [EXP_WIDTH-1:0]       out_exp;
  logic [IDX_W-1:0]           out_lane;

  modport master (
    output in_valid, in_exp, out_ready,
    input  in_ready, out_valid, out_exp, out_lane
  );

  modport slave (
    input  in_valid, in_exp, out_ready,
    output in_ready, out_valid, out_exp, out_lane
  );
endinterface

// File: rtl/block_max_exp_stream.sv
// Pipelined block-exponent finder: registered 2-input max tree per beat, then a
// running max over BEATS beats; reports the first (lowest-index) maximum.
module block_max_exp_stream #(
  parameter int EXP_WIDTH  = 4,
  parameter int LANES      = 16,
  parameter int BEATS      = 4,
  parameter int SIGNED_EXP = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  block_max_exp_stream_if.slave strm
);

  localparam int L     = $clog2(LANES);
  localparam int HALF  = LANES / 2;
  localparam int IDX_W = $clog2(LANES * BEATS);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  function automatic logic gt(input logic [EXP_WIDTH-1:0] a,
                              input logic [EXP_WIDTH-1:0] b);
    if (SIGNED_EXP != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic en;
  logic out_valid_q;

  // One global stall: everything freezes while a result waits for the consumer.
  assign en            = ~(out_valid_q & ~strm.out_ready);
  assign strm.in_ready = en;

  // Heap-ordered tree: node i has children 2i and 2i+1; indices >= LANES are
  // the input lanes, so node 1 is the root and every level is one register.
  logic [EXP_WIDTH-1:0] node_exp [LANES];
  logic [L-1:0]         node_lane[LANES];
  logic [EXP_WIDTH-1:0] lo_exp   [LANES];
  logic [EXP_WIDTH-1:0] hi_exp   [LANES];
  logic [L-1:0]         lo_lane  [LANES];
  logic [L-1:0]         hi_lane  [LANES];
  logic [L-1:0]         lvl_vld;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      // NOTE: every output gets a value on every path, so no latch is inferred.
      lo_exp[i]  = '0;
      hi_exp[i]  = '0;
      lo_lane[i] = '0;
      hi_lane[i] = '0;
      if (i >= HALF) begin
        lo_exp[i]  = strm.in_exp[(2*i-LANES)*EXP_WIDTH +: EXP_WIDTH];
        hi_exp[i]  = strm.in_exp[(2*i+1-LANES)*EXP_WIDTH +: EXP_WIDTH];
        lo_lane[i] = L'(2*i - LANES);
        hi_lane[i] = L'(2*i + 1 - LANES);
      end else if (i >= 1) begin
        lo_exp[i]  = node_exp[2*i];
        hi_exp[i]  = node_exp[2*i+1];
        lo_lane[i] = node_lane[2*i];
        hi_lane[i] = node_lane[2*i+1];
      end
    end
  end

  // NOTE: the tree payload is qualified by lvl_vld, so it carries no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 1; i < LANES; i++) begin
        // The higher-index child wins only when strictly larger.
        if (gt(hi_exp[i], lo_exp[i])) begin
          node_exp[i]  <= hi_exp[i];
          node_lane[i] <= hi_lane[i];
        end else begin
          node_exp[i]  <= lo_exp[i];
          node_lane[i] <= lo_lane[i];
        end
      end
    end
  end

  // lvl_vld[L-1] belongs to the level nearest the inputs, lvl_vld[0] to the root.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from before the clock edge.
    if (!rst_n)   lvl_vld <= '0;
    else if (clr) lvl_vld <= '0;
    else if (en)  lvl_vld <= L'({strm.in_valid, lvl_vld} >> 1);
  end

  logic                 tree_valid;
  logic [EXP_WIDTH-1:0] tree_exp;
  logic [IDX_W-1:0]     tree_idx;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 last_beat;
  logic [EXP_WIDTH-1:0] acc_exp;
  logic [IDX_W-1:0]     acc_idx;
  logic                 take_tree;
  logic [EXP_WIDTH-1:0] merged_exp;
  logic [IDX_W-1:0]     merged_idx;
  logic [EXP_WIDTH-1:0] out_exp_q;
  logic [IDX_W-1:0]     out_lane_q;

  assign tree_valid = lvl_vld[0];
  assign tree_exp   = node_exp[1];
  assign tree_idx   = (IDX_W'(beat_cnt) << L) | IDX_W'(node_lane[1]);
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));

  // beat_cnt == 0 means the accumulator is empty; on a tie the older beat stays.
  assign take_tree  = (beat_cnt == '0) || gt(tree_exp, acc_exp);
  assign merged_exp = take_tree ? tree_exp : acc_exp;
  assign merged_idx = take_tree ? tree_idx : acc_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      acc_exp     <= '0;
      acc_idx     <= '0;
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      out_lane_q  <= '0;
    end else if (clr) begin
      beat_cnt    <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      // en implies any pending result is consumed now, so a completion here
      // is the only way out_valid stays high.
      out_valid_q <= tree_valid & last_beat;
      if (tree_valid) begin
        acc_exp <= merged_exp;
        acc_idx <= merged_idx;
        if (last_beat) begin
          beat_cnt   <= '0;
          out_exp_q  <= merged_exp;
          out_lane_q <= merged_idx;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_exp   = out_exp_q;
  assign strm.out_lane  = out_lane_q;

endmodule
